// File: rtl/uart_mem_loader.sv
// uart_mem_loader: parses framed write packets arriving byte-by-byte from the
// UART receiver, buffers the payload words, verifies a CRC-8 over the frame
// and commits clean frames to the 16-bit data memory one word per cycle.
module uart_mem_loader #(
  parameter int unsigned MAX_WORDS   = 8,
  parameter int unsigned MEM_DEPTH   = 512,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter logic [7:0]  HEADER      = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        crc_err,
  output logic        frame_err,
  output logic        overrun
);

  localparam int unsigned IW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR_HI = 3'd1,
    ST_ADDR_LO = 3'd2,
    ST_LEN     = 3'd3,
    ST_DATA_HI = 3'd4,
    ST_DATA_LO = 3'd5,
    ST_CRC     = 3'd6,
    ST_COMMIT  = 3'd7
  } state_t;

  state_t        state_r;
  logic [15:0]   start_r;
  logic [7:0]    len_r;
  logic [7:0]    idx_r;
  logic [7:0]    data_hi_r;
  logic [7:0]    crc_r;
  logic [TW-1:0] tmo_r;
  logic [15:0]   buf_r [MAX_WORDS];

  logic [7:0]    crc_next_s;
  logic [16:0]   end_addr_s;
  logic [7:0]    idx_inc_s;
  logic          len_bad_s;

  // CRC-8 (poly 0x07, MSB first) advanced by one byte
  function automatic logic [7:0] crc8_update(input logic [7:0] crc_in, input logic [7:0] data);
    logic [7:0] c;
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) begin
        c = {c[6:0], 1'b0} ^ 8'h07;
      end else begin
        c = {c[6:0], 1'b0};
      end
    end
    return c;
  endfunction

  // Byte-derived helpers: running CRC, frame end address and LEN validity
  always_comb begin
    crc_next_s = crc8_update(crc_r, rx_byte);
    end_addr_s = {1'b0, start_r} + {9'd0, rx_byte};
    idx_inc_s  = idx_r + 8'd1;
    if ((rx_byte == 8'd0) || (rx_byte > 8'(MAX_WORDS)) || (end_addr_s > 17'(MEM_DEPTH))) begin
      len_bad_s = 1'b1;
    end else begin
      len_bad_s = 1'b0;
    end
  end

  // Frame parser, inter-byte timeout and commit sequencer with registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      start_r   <= 16'd0;
      len_r     <= 8'd0;
      idx_r     <= 8'd0;
      data_hi_r <= 8'd0;
      crc_r     <= 8'd0;
      tmo_r     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= 16'd0;
      mem_wdata <= 16'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      crc_err   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      done      <= 1'b0;
      crc_err   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      mem_we    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          tmo_r <= '0;
          if (rx_valid && (rx_byte == HEADER)) begin
            state_r <= ST_ADDR_HI;
            crc_r   <= 8'd0;
            idx_r   <= 8'd0;
            busy    <= 1'b1;
          end
        end
        ST_COMMIT: begin
          // Incoming bytes cannot be buffered while draining; flag and drop them
          tmo_r <= '0;
          if (rx_valid) begin
            overrun <= 1'b1;
          end
          if (idx_r == len_r) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            mem_we    <= 1'b1;
            mem_addr  <= start_r + {8'd0, idx_r};
            mem_wdata <= buf_r[idx_r[IW-1:0]];
            idx_r     <= idx_inc_s;
          end
        end
        default: begin
          // In-frame states: advance on each byte, abort on a silent link
          if (!rx_valid) begin
            if (tmo_r == TW'(TIMEOUT_CYC - 1)) begin
              frame_err <= 1'b1;
              busy      <= 1'b0;
              state_r   <= ST_IDLE;
              tmo_r     <= '0;
            end else begin
              tmo_r <= tmo_r + TW'(1);
            end
          end else begin
            tmo_r <= '0;
            case (state_r)
              ST_ADDR_HI: begin
                start_r[15:8] <= rx_byte;
                crc_r         <= crc_next_s;
                state_r       <= ST_ADDR_LO;
              end
              ST_ADDR_LO: begin
                start_r[7:0] <= rx_byte;
                crc_r        <= crc_next_s;
                state_r      <= ST_LEN;
              end
              ST_LEN: begin
                if (len_bad_s) begin
                  frame_err <= 1'b1;
                  busy      <= 1'b0;
                  state_r   <= ST_IDLE;
                end else begin
                  len_r   <= rx_byte;
                  crc_r   <= crc_next_s;
                  state_r <= ST_DATA_HI;
                end
              end
              ST_DATA_HI: begin
                data_hi_r <= rx_byte;
                crc_r     <= crc_next_s;
                state_r   <= ST_DATA_LO;
              end
              ST_DATA_LO: begin
                buf_r[idx_r[IW-1:0]] <= {data_hi_r, rx_byte};
                idx_r                <= idx_inc_s;
                crc_r                <= crc_next_s;
                if (idx_inc_s == len_r) begin
                  state_r <= ST_CRC;
                end else begin
                  state_r <= ST_DATA_HI;
                end
              end
              ST_CRC: begin
                if (rx_byte == crc_r) begin
                  // First word goes out on this edge so writes start one cycle after the CRC byte
                  mem_we    <= 1'b1;
                  mem_addr  <= start_r;
                  mem_wdata <= buf_r[0];
                  idx_r     <= 8'd1;
                  state_r   <= ST_COMMIT;
                end else begin
                  crc_err <= 1'b1;
                  busy    <= 1'b0;
                  state_r <= ST_IDLE;
                end
              end
              default: begin
                busy    <= 1'b0;
                state_r <= ST_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Testbench for uart_mem_loader: directed frames plus randomized frames
// checked against a frame-level reference model kept in the bench.
module tb_uart_mem_loader;

  localparam int TMO   = 200;
  localparam int MAXW  = 8;
  localparam int DEPTH = 512;

  typedef logic [7:0] bq_t[$];

  logic        clk      = 1'b0;
  logic        reset    = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte  = 8'h00;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        crc_err;
  logic        frame_err;
  logic        overrun;

  int total = 0;
  int bad   = 0;
  int n_done = 0;
  int n_crc = 0;
  int n_frame = 0;
  int n_ovr = 0;
  logic [31:0] obs_q[$];
  logic [31:0] exp_q[$];

  uart_mem_loader #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .crc_err(crc_err), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: sample 1 ns after the edge, log writes and pulses
  task automatic tick();
    @(posedge clk);
    #1;
    if (mem_we === 1'b1) obs_q.push_back({mem_addr, mem_wdata});
    if (done === 1'b1) n_done++;
    if (crc_err === 1'b1) n_crc++;
    if (frame_err === 1'b1) n_frame++;
    if (overrun === 1'b1) n_ovr++;
    check("pulse_excl", {31'd0, ($countones({crc_err, frame_err, overrun}) <= 1)}, 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input bq_t fr, input int maxgap);
    for (int i = 0; i < fr.size(); i++) begin
      send_byte(fr[i]);
      if (i != fr.size() - 1) repeat ($urandom_range(0, maxgap)) tick();
    end
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && n_done == 0; i++) tick();
  endtask

  task automatic clear_stats();
    n_done = 0; n_crc = 0; n_frame = 0; n_ovr = 0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_nwr"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), obs_q[i], exp_q[i]);
  endtask

  task automatic check_pulses(input string tag, input int d, input int c, input int f, input int o);
    check({tag, "_done"}, n_done, d);
    check({tag, "_crcerr"}, n_crc, c);
    check({tag, "_frameerr"}, n_frame, f);
    check({tag, "_overrun"}, n_ovr, o);
  endtask

  // CRC as the remainder of (message * x^8) divided by x^8+x^2+x+1
  function automatic logic [7:0] crc_ref(input bq_t fr, input int lo, input int hi);
    logic [8:0] rem;
    logic [7:0] v;
    rem = 9'd0;
    for (int i = lo; i <= hi + 1; i++) begin
      v = (i <= hi) ? fr[i] : 8'h00;
      for (int b = 7; b >= 0; b--) begin
        rem = {rem[7:0], v[b]};
        if (rem[8]) rem = rem ^ 9'h107;
      end
    end
    return rem[7:0];
  endfunction

  // Frame-level model: 0 = commit (expected writes queued), 1 = CRC error, 2 = frame error
  function automatic int ref_model(input bq_t fr);
    int start;
    int len;
    start = int'({fr[1], fr[2]});
    len   = int'(fr[3]);
    if (len < 1 || len > MAXW || start + len > DEPTH) return 2;
    if (crc_ref(fr, 1, 3 + 2 * len) != fr[4 + 2 * len]) return 1;
    for (int k = 0; k < len; k++) exp_q.push_back({16'(start + k), fr[4 + 2 * k], fr[5 + 2 * k]});
    return 0;
  endfunction

  function automatic bq_t make_frame(input logic [15:0] start, input logic [7:0] len);
    bq_t fr;
    fr.push_back(8'hA5);
    fr.push_back(start[15:8]);
    fr.push_back(start[7:0]);
    fr.push_back(len);
    for (int k = 0; k < int'(len); k++) begin
      fr.push_back(8'($urandom));
      fr.push_back(8'($urandom));
    end
    fr.push_back(crc_ref(fr, 1, fr.size() - 1));
    return fr;
  endfunction

  initial begin
    bq_t fr;
    int  outcome;
    int  got;

    // Reset state
    reset = 1'b0;
    tick();
    tick();
    check("rst_flags", {26'd0, mem_we, busy, done, crc_err, frame_err, overrun}, 32'd0);
    check("rst_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_wdata", {16'd0, mem_wdata}, 32'd0);
    reset = 1'b1;
    tick();

    // Basic frame: one write at 0x0010, done next cycle
    clear_stats();
    fr = '{8'hA5, 8'h00, 8'h10, 8'h01, 8'h12, 8'h34, 8'hFD};
    for (int i = 0; i < 6; i++) send_byte(fr[i]);
    check("basic_busy_mid", {31'd0, busy}, 32'd1);
    send_byte(fr[6]);
    check("basic_we", {31'd0, mem_we}, 32'd1);
    check("basic_addr", {16'd0, mem_addr}, 32'h0010);
    check("basic_wdata", {16'd0, mem_wdata}, 32'h1234);
    tick();
    check("basic_done_flags", {29'd0, mem_we, done, busy}, 32'b010);
    repeat (3) tick();
    check("basic_nwr", obs_q.size(), 32'd1);
    check("basic_mem_hold", {mem_addr, mem_wdata}, 32'h0010_1234);

    // Bad CRC, then the same frame with a good CRC
    clear_stats();
    fr[6] = 8'h00;
    send_frame(fr, 0);
    check("crc_flags", {29'd0, crc_err, busy, mem_we}, 32'b100);
    repeat (3) tick();
    check("crc_nwr", obs_q.size(), 32'd0);
    check_pulses("crc", 0, 1, 0, 0);
    clear_stats();
    fr[6] = 8'hFD;
    outcome = ref_model(fr);
    send_frame(fr, 1);
    wait_done(10);
    compare_writes("after_crc");
    check_pulses("after_crc", 1, 0, 0, 0);

    // LEN errors with trailing bytes that must be ignored
    for (int t = 0; t < 3; t++) begin
      clear_stats();
      case (t)
        0:       fr = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h12, 8'h34, 8'h56};
        1:       fr = '{8'hA5, 8'h00, 8'h10, 8'h09, 8'h12, 8'h34, 8'h56};
        default: fr = '{8'hA5, 8'h01, 8'hFF, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
      endcase
      for (int i = 0; i < fr.size(); i++) begin
        send_byte(fr[i]);
        if (i == 3) check($sformatf("lenerr%0d_pulse", t), {30'd0, frame_err, busy}, 32'b10);
      end
      repeat (3) tick();
      check($sformatf("lenerr%0d_busy", t), {31'd0, busy}, 32'd0);
      check($sformatf("lenerr%0d_nwr", t), obs_q.size(), 32'd0);
      check_pulses($sformatf("lenerr%0d", t), 0, 0, 1, 0);
    end

    // 8 words at the top edge of memory, with 3 strobes during commit
    clear_stats();
    fr = make_frame(16'h01F8, 8'd8);
    outcome = ref_model(fr);
    check("ovr_model_ok", outcome, 32'd0);
    send_frame(fr, 0);
    for (int c = 1; c <= 12 && n_done == 0; c++) begin
      if (c == 2 || c == 4 || c == 6) begin
        rx_valid = 1'b1;
        rx_byte  = 8'hA5;
      end
      tick();
      rx_valid = 1'b0;
    end
    compare_writes("ovr");
    check_pulses("ovr", 1, 0, 0, 3);
    check("ovr_busy", {31'd0, busy}, 32'd0);

    // Inter-byte timeout
    clear_stats();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h10);
    got = -1;
    for (int k = 1; k <= TMO + 5; k++) begin
      tick();
      if (frame_err === 1'b1) begin
        got = k;
        break;
      end
    end
    check("tmo_cycles", got, TMO);
    check("tmo_busy", {31'd0, busy}, 32'd0);
    clear_stats();
    fr = make_frame(16'(($urandom_range(0, 500))), 8'(($urandom_range(1, 8))));
    outcome = ref_model(fr);
    send_frame(fr, 2);
    wait_done(20);
    compare_writes("post_tmo");
    check_pulses("post_tmo", 1, 0, 0, 0);

    // Reset asserted during the 4th commit cycle of an 8-word frame
    clear_stats();
    fr = make_frame(16'(($urandom_range(0, 504))), 8'd8);
    outcome = ref_model(fr);
    send_frame(fr, 0);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("midrst_flags", {26'd0, mem_we, busy, done, crc_err, frame_err, overrun}, 32'd0);
    check("midrst_bus", {mem_addr, mem_wdata}, 32'd0);
    tick();
    reset = 1'b1;
    repeat (3) tick();
    check("midrst_nwr_3or4", {31'd0, (obs_q.size() == 3 || obs_q.size() == 4)}, 32'd1);
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check($sformatf("midrst_wr%0d", i), obs_q[i], exp_q[i]);
    check("midrst_done", n_done, 32'd0);
    clear_stats();
    fr = make_frame(16'(($urandom_range(0, 500))), 8'(($urandom_range(1, 8))));
    outcome = ref_model(fr);
    send_frame(fr, 1);
    wait_done(20);
    compare_writes("post_rst");
    check_pulses("post_rst", 1, 0, 0, 0);

    // Randomized frames; a good frame's successor starts in its done cycle
    for (int f = 0; f < 24; f++) begin
      logic [15:0] st;
      logic [7:0]  ln;
      st = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(500, 511)) : 16'($urandom_range(0, 511));
      ln = 8'($urandom_range(0, 9));
      fr = make_frame(st, ln);
      if ($urandom_range(0, 3) == 0) fr[fr.size() - 1] = fr[fr.size() - 1] ^ 8'($urandom_range(1, 255));
      clear_stats();
      outcome = ref_model(fr);
      if (outcome == 2) begin
        for (int i = 0; i < 4; i++) send_byte(fr[i]);
        tick();
      end else begin
        send_frame(fr, 2);
        if (outcome == 0) wait_done(20);
        else tick();
      end
      compare_writes($sformatf("rnd%0d", f));
      check_pulses($sformatf("rnd%0d", f), (outcome == 0) ? 1 : 0, (outcome == 1) ? 1 : 0,
                   (outcome == 2) ? 1 : 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
